// File: rtl/pipe_pkg.sv
// pipe_pkg: shared hazard-FSM state encoding and load-latency limits.
package pipe_pkg;
  typedef enum logic [1:0] {IDLE, LSTALL, MWAIT} hz_state_e;
  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 7;
endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational load-use hazard detection against the ID sources.
module hazard_cmp #(
  parameter int REG_AW = 5
) (
  input  logic              id_ex_mem_read_i,
  input  logic [REG_AW-1:0] id_ex_rt_i,
  input  logic [REG_AW-1:0] if_id_rs_i,
  input  logic [REG_AW-1:0] if_id_rt_i,
  input  logic              if_id_use_rt_i,
  output logic              hazard_o
);
  assign hazard_o = id_ex_mem_read_i && (|id_ex_rt_i) &&
                    (id_ex_rt_i == if_id_rs_i || (if_id_use_rt_i && id_ex_rt_i == if_id_rt_i));
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use stall / memory-freeze control FSM with saturating stall counter.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_ex_mem_read_i,
  input  logic [REG_AW-1:0] id_ex_rt_i,
  input  logic [REG_AW-1:0] if_id_rs_i,
  input  logic [REG_AW-1:0] if_id_rt_i,
  input  logic              if_id_use_rt_i,
  input  logic              branch_taken_i,
  input  logic              dmem_busy_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              id_ex_nop_o,
  output logic              if_id_flush_o,
  output logic              pipe_freeze_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  localparam int LAT = LOAD_LAT < LOAD_LAT_MIN ? LOAD_LAT_MIN :
                       LOAD_LAT > LOAD_LAT_MAX ? LOAD_LAT_MAX : LOAD_LAT;
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);
  hz_state_e state_q, state_d, st;
  logic [2:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic hazard, bubble, stall;
  hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
    .id_ex_mem_read_i(id_ex_mem_read_i),
    .id_ex_rt_i      (id_ex_rt_i),
    .if_id_rs_i      (if_id_rs_i),
    .if_id_rt_i      (if_id_rt_i),
    .if_id_use_rt_i  (if_id_use_rt_i),
    .hazard_o        (hazard)
  );
  // Once memory releases, MWAIT behaves as the state it interrupted, so the
  // release cycle is already a bubble when load-stall cycles are still owed.
  always_comb begin
    st = rst_i ? IDLE : state_q == MWAIT ? (cnt_q == 3'd0 ? IDLE : LSTALL) : state_q;
    bubble = !dmem_busy_i && (st == LSTALL || (st == IDLE && hazard));
    stall = dmem_busy_i || bubble;
    pipe_freeze_o = dmem_busy_i;
    pc_write_o = !stall;
    if_id_write_o = !stall;
    id_ex_nop_o = bubble;
    if_id_flush_o = !stall && branch_taken_i;
    state_d = dmem_busy_i ? MWAIT :
              st == LSTALL ? (cnt_q == 3'd1 ? IDLE : LSTALL) :
              (hazard && LAT > 1) ? LSTALL : IDLE;
    cnt_d = dmem_busy_i ? cnt_q : st == LSTALL ? cnt_q - 3'd1 : hazard ? CNT_INIT : 3'd0;
    stall_d = (stall && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= 3'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
    end
  end
  assign stall_cnt_o = stall_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random checks of two hazard_unit configurations against a stall-budget model.
module tb_hazard_unit;
  logic clk = 0;
  logic rst = 1;
  logic mr = 0, use_rt = 0, br = 0, busy = 0;
  logic [4:0] lrt = 0, rs = 0, rt = 0;
  logic [1:0] pw, iw, nop, fl, fz;
  logic [15:0] sc1;
  logic [3:0] sc3;
  int n_chk = 0, n_fail = 0;
  int pend[2] = '{0, 0};
  int stalls[2] = '{0, 0};
  int lat[2] = '{1, 3};
  int smax[2] = '{65535, 15};

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u1 (
    .clk_i(clk), .rst_i(rst), .id_ex_mem_read_i(mr), .id_ex_rt_i(lrt),
    .if_id_rs_i(rs), .if_id_rt_i(rt), .if_id_use_rt_i(use_rt),
    .branch_taken_i(br), .dmem_busy_i(busy),
    .pc_write_o(pw[0]), .if_id_write_o(iw[0]), .id_ex_nop_o(nop[0]),
    .if_id_flush_o(fl[0]), .pipe_freeze_o(fz[0]), .stall_cnt_o(sc1)
  );
  hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) u3 (
    .clk_i(clk), .rst_i(rst), .id_ex_mem_read_i(mr), .id_ex_rt_i(lrt),
    .if_id_rs_i(rs), .if_id_rt_i(rt), .if_id_use_rt_i(use_rt),
    .branch_taken_i(br), .dmem_busy_i(busy),
    .pc_write_o(pw[1]), .if_id_write_o(iw[1]), .id_ex_nop_o(nop[1]),
    .if_id_flush_o(fl[1]), .pipe_freeze_o(fz[1]), .stall_cnt_o(sc3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // One pipeline cycle: drive, check at negedge, advance the model at posedge.
  task automatic step(input logic m, input logic [4:0] l, input logic [4:0] s, input logic [4:0] t,
                      input logic u, input logic b, input logic bz, input logic r);
    bit hz, bub[2];
    int p[2];
    mr = m; lrt = l; rs = s; rt = t; use_rt = u; br = b; busy = bz; rst = r;
    @(negedge clk);
    hz = m && l != 0 && (l == s || (u && l == t));
    for (int k = 0; k < 2; k++) begin
      p[k] = r ? 0 : pend[k];
      bub[k] = !bz && (p[k] > 0 || hz);
      chk($sformatf("pc_write[%0d]", k), 32'(pw[k]), 32'(!bz && !bub[k]));
      chk($sformatf("if_id_write[%0d]", k), 32'(iw[k]), 32'(!bz && !bub[k]));
      chk($sformatf("id_ex_nop[%0d]", k), 32'(nop[k]), 32'(bub[k]));
      chk($sformatf("freeze[%0d]", k), 32'(fz[k]), 32'(bz));
      chk($sformatf("flush[%0d]", k), 32'(fl[k]), 32'(!bz && !bub[k] && b));
      chk($sformatf("stall_cnt[%0d]", k), k == 0 ? 32'(sc1) : 32'(sc3), 32'(stalls[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        pend[k] = 0;
        stalls[k] = 0;
      end else begin
        if ((bz || bub[k]) && stalls[k] < smax[k]) stalls[k]++;
        if (!bz) pend[k] = p[k] > 0 ? p[k] - 1 : hz ? lat[k] - 1 : 0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("reset_cnt1", 32'(sc1), 0);
    chk("reset_cnt3", 32'(sc3), 0);
    step(1, 5, 5, 0, 0, 0, 0, 0);
    idle(4);
    chk("lat1_rs_cnt", 32'(sc1), 1);
    chk("lat3_rs_cnt", 32'(sc3), 3);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 7, 1, 7, 1, 0, 0, 0);
    idle(4);
    chk("lat3_rt_cnt", 32'(sc3), 3);
    step(1, 7, 1, 7, 0, 0, 0, 0);
    idle(4);
    chk("no_use_rt_cnt", 32'(sc3), 3);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    chk("r0_cnt", 32'(sc3), 3);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 9, 9, 0, 0, 0, 0, 0);
    step(0, 0, 9, 0, 0, 0, 0, 0);
    step(0, 0, 9, 0, 0, 0, 1, 0);
    step(0, 0, 9, 0, 0, 0, 1, 0);
    step(0, 0, 9, 0, 0, 0, 0, 0);
    idle(2);
    chk("freeze_mid_cnt", 32'(sc3), 5);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 4, 4, 0, 0, 1, 0, 0);
    step(0, 0, 4, 0, 0, 1, 0, 0);
    step(0, 0, 4, 0, 0, 1, 0, 0);
    step(0, 0, 4, 0, 0, 1, 0, 0);
    chk("branch_after_flush", 32'(fl[1]), 1);
    idle(1);
    step(1, 6, 6, 0, 0, 0, 0, 0);
    step(0, 0, 6, 0, 0, 0, 0, 0);
    step(0, 0, 6, 0, 0, 0, 0, 1);
    chk("rst_mid_cnt", 32'(sc3), 0);
    chk("rst_mid_pcw", 32'(pw[1]), 1);
    idle(2);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("sat_cnt", 32'(sc3), 15);
    step(1, 2, 2, 0, 0, 0, 0, 0);
    idle(3);
    chk("sat_hold", 32'(sc3), 15);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
